dmac_channel_datapath: RTL and testbench
========================================

Name: dmac_channel_datapath

Overview:
Address/count datapath of one DMA channel, driven by the channel controller's select/enable strobes. It returns the `bsz`, `tsz` and `tslb` status flags that the controller branches on. It holds the source address, destination address, remaining transfer size, burst length and beat counter, and drives `haddr`/`hsize` to the AHB master port.

Parameters:
ADDR_W, 32, address width of the src/dst registers and `haddr`.
TS_W, 16, width of the transfer-size (beat) counter.
BURST_W, 5, width of the burst-length and beat registers.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cfg_src_addr  input  ADDR_W  programmed source start address
cfg_dst_addr  input  ADDR_W  programmed destination start address
cfg_trans_size  input  TS_W  total beats to move
cfg_burst_size  input  BURST_W  beats per burst; 0 is treated as 1
cfg_hsize  input  2  beat size: 0 = byte, 1 = half, 2 = word; 3 is treated as word
s_sel, d_sel, t_sel, b_sel, h_sel  input  1 each  select strobes from the controller
s_en, d_en, ts_en, burst_en, count_en  input  1 each  enable strobes from the controller
haddr  output  ADDR_W  AHB address
hsize  output  3  AHB HSIZE = {1'b0, cfg_hsize}, with 3 mapped to 2
bsz  output  1  burst beat counter is zero
tsz  output  1  remaining transfer size is zero
tslb  output  1  remaining size is less than the programmed burst
src_q, dst_q  output  ADDR_W each  current address registers (debug/status)
ts_q  output  TS_W  remaining beats

Behaviour:
- Clock and reset:
  - Single clock, registers update on posedge `clk`.
  - `rst_n` low asynchronously forces: src_q = 0, dst_q = 0, ts_q = 0, blen = 1, bc = 0.
  - Resulting outputs in reset: `haddr` = 0, `bsz` = 1, `tsz` = 1, `tslb` = 1 (when the effective cfg burst > 0).
  - Reset asserted mid-transfer discards all state; there is no recovery.
- Derived values:
  - inc = 1 << min(cfg_hsize, 2).
  - eff_cfg_burst = (cfg_burst_size == 0) ? 1 : cfg_burst_size.
- Source register:
  - `s_en` & `s_sel`: src_q <= cfg_src_addr.
  - `s_en` & !`s_sel`: src_q <= src_q + inc, modulo 2^ADDR_W (wraps, no flag).
- Destination register:
  - Same rules as source, using `d_en`, `d_sel` and cfg_dst_addr.
- Transfer size:
  - `ts_en` & `t_sel`: ts_q <= cfg_trans_size.
  - `ts_en` & !`t_sel`: ts_q <= ts_q − blen, saturating at 0.
- Burst length (blen):
  - `burst_en` & !`b_sel`: blen <= eff_cfg_burst.
  - `burst_en` & `b_sel`: blen <= max(ts_q[BURST_W-1:0], 1). This is the last short burst; it is only legal while `tslb` = 1.
  - Any `burst_en` also clears bc to 0.
- Beat counter (bc):
  - `count_en` with bc == 0: bc <= blen − 1.
  - `count_en` with bc != 0: bc <= bc − 1.
  - Result: exactly blen `count_en` pulses per address phase, with `bsz` high again after the last one.
  - `count_en` in the same cycle as `burst_en`: `burst_en` wins (bc = 0) and `count_en` is ignored.
- Simultaneous `ts_en` & `burst_en`/`b_sel`: both registers use pre-edge values; the decrement uses the old blen.
- Combinational outputs (no added latency):
  - `bsz` = (bc == 0).
  - `tsz` = (ts_q == 0).
  - `tslb` = (ts_q < eff_cfg_burst).
  - `haddr` = `h_sel` ? dst_q : src_q.
  - `hsize` as described under Ports.
- Strobes act only on their own register; no cross-register side effects except `burst_en` clearing bc.
- No AHB protocol checking is done here; `HTrans` and `write` come from the controller.

Test Plan:
1. Load and flags: cfg src=0x1000, dst=0x2000, ts=8, burst=4, hsize=2; pulse s_en, d_en, ts_en, burst_en with all sels=1 -> src_q=0x1000, dst_q=0x2000, ts_q=8, tsz=0, tslb=0, bsz=1, haddr=0x1000.
2. Beat counting: after (1), 4 cycles of count_en+s_en (s_sel=0) -> bsz sequence after each edge is 0,0,0,1; src_q=0x1010; with h_sel=1, haddr=0x2000.
3. Size decrement: after (1), ts_en with t_sel=0 twice -> ts_q 8→4→0; tsz=1 only after the second edge.
4. Short last burst: ts=6, burst=4; one decrement -> ts_q=2, tslb=1; burst_en+b_sel -> blen=2, bc=0; 2 count_en pulses -> bsz 0 then 1; decrement -> ts_q=0, tsz=1.
5. Edge arithmetic:
   - burst=0: 1 count_en keeps bsz=1.
   - src=0xFFFFFFFC, hsize=2, s_en increment -> src_q=0x00000000.
   - hsize=0 -> increment of 1.
   - ts_en decrement with ts_q=3, blen=4 -> ts_q=0 (saturates).
6. Async reset: mid-burst (bc=2, ts_q=5), drop rst_n between clock edges -> outputs immediately haddr=0, bsz=1, tsz=1; registers stay cleared until rst_n rises, and the next load works normally.

Source files
------------

// File: rtl/dmac_channel_datapath.sv
// Address/count datapath for one DMA channel: source/destination address
// registers, remaining transfer size, burst length and beat counter, plus the
// status flags the channel controller branches on.
module dmac_channel_datapath #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TS_W    = 16,
    parameter int unsigned BURST_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  cfg_src_addr,
    input  logic [ADDR_W-1:0]  cfg_dst_addr,
    input  logic [TS_W-1:0]    cfg_trans_size,
    input  logic [BURST_W-1:0] cfg_burst_size,
    input  logic [1:0]         cfg_hsize,
    input  logic               s_sel,
    input  logic               d_sel,
    input  logic               t_sel,
    input  logic               b_sel,
    input  logic               h_sel,
    input  logic               s_en,
    input  logic               d_en,
    input  logic               ts_en,
    input  logic               burst_en,
    input  logic               count_en,
    output logic [ADDR_W-1:0]  haddr,
    output logic [2:0]         hsize,
    output logic               bsz,
    output logic               tsz,
    output logic               tslb,
    output logic [ADDR_W-1:0]  src_q,
    output logic [ADDR_W-1:0]  dst_q,
    output logic [TS_W-1:0]    ts_q
);

    logic [ADDR_W-1:0]  src_d;
    logic [ADDR_W-1:0]  dst_d;
    logic [TS_W-1:0]    ts_d;
    logic [BURST_W-1:0] blen_q, blen_d;
    logic [BURST_W-1:0] bc_q, bc_d;

    logic [ADDR_W-1:0]  inc;
    logic [BURST_W-1:0] eff_burst;
    logic [BURST_W-1:0] ts_low;
    logic [TS_W-1:0]    blen_ext;
    logic [TS_W-1:0]    eff_burst_ext;

    // Derived quantities: address increment per beat and effective burst length.
    always_comb begin
        eff_burst = (cfg_burst_size == '0) ? BURST_W'(1) : cfg_burst_size;
        case (cfg_hsize)
            2'd0:    inc = ADDR_W'(1);
            2'd1:    inc = ADDR_W'(2);
            default: inc = ADDR_W'(4);
        endcase
        blen_ext      = TS_W'(blen_q);
        eff_burst_ext = TS_W'(eff_burst);
        ts_low        = ts_q[BURST_W-1:0];
    end

    // Next-state for all datapath registers; every update uses pre-edge values.
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        ts_d   = ts_q;
        blen_d = blen_q;
        bc_d   = bc_q;

        if (s_en) begin
            src_d = s_sel ? cfg_src_addr : src_q + inc;
        end
        if (d_en) begin
            dst_d = d_sel ? cfg_dst_addr : dst_q + inc;
        end
        if (ts_en) begin
            if (t_sel) begin
                ts_d = cfg_trans_size;
            end else begin
                // Saturating decrement by the current burst length.
                ts_d = (ts_q > blen_ext) ? ts_q - blen_ext : '0;
            end
        end
        if (burst_en) begin
            if (b_sel) begin
                // Last short burst: whatever remains, but never zero.
                blen_d = (ts_low == '0) ? BURST_W'(1) : ts_low;
            end else begin
                blen_d = eff_burst;
            end
            bc_d = '0;  // burst_en overrides any concurrent count_en
        end else if (count_en) begin
            bc_d = (bc_q == '0) ? blen_q - BURST_W'(1) : bc_q - BURST_W'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            ts_q   <= '0;
            blen_q <= BURST_W'(1);
            bc_q   <= '0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            ts_q   <= ts_d;
            blen_q <= blen_d;
            bc_q   <= bc_d;
        end
    end

    // Combinational status flags and AHB address/size.
    always_comb begin
        bsz   = (bc_q == '0);
        tsz   = (ts_q == '0);
        tslb  = (ts_q < eff_burst_ext);
        haddr = h_sel ? dst_q : src_q;
        hsize = {1'b0, (cfg_hsize == 2'd3) ? 2'd2 : cfg_hsize};
    end

endmodule

// File: tb/tb_dmac_channel_datapath.sv
// Scoreboard bench for dmac_channel_datapath: directed scenarios followed by
// random strobes, checked against a behavioural channel model.
module tb_dmac_channel_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_src_addr, cfg_dst_addr;
    logic [15:0] cfg_trans_size;
    logic [4:0]  cfg_burst_size;
    logic [1:0]  cfg_hsize;
    logic        s_sel, d_sel, t_sel, b_sel, h_sel;
    logic        s_en, d_en, ts_en, burst_en, count_en;
    logic [31:0] haddr, src_q, dst_q;
    logic [2:0]  hsize;
    logic        bsz, tsz, tslb;
    logic [15:0] ts_q;

    dmac_channel_datapath #(
        .ADDR_W  (32),
        .TS_W    (16),
        .BURST_W (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_src_addr   (cfg_src_addr),
        .cfg_dst_addr   (cfg_dst_addr),
        .cfg_trans_size (cfg_trans_size),
        .cfg_burst_size (cfg_burst_size),
        .cfg_hsize      (cfg_hsize),
        .s_sel          (s_sel),
        .d_sel          (d_sel),
        .t_sel          (t_sel),
        .b_sel          (b_sel),
        .h_sel          (h_sel),
        .s_en           (s_en),
        .d_en           (d_en),
        .ts_en          (ts_en),
        .burst_en       (burst_en),
        .count_en       (count_en),
        .haddr          (haddr),
        .hsize          (hsize),
        .bsz            (bsz),
        .tsz            (tsz),
        .tslb           (tslb),
        .src_q          (src_q),
        .dst_q          (dst_q),
        .ts_q           (ts_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint unsigned src;
        longint unsigned dst;
        int              ts;
        longint unsigned haddr;
        int              hsize;
        bit              bsz;
        bit              tsz;
        bit              tslb;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    event mon_ev;

    // Behavioural model: addresses, remaining beats, burst length, and how many
    // beats have been counted inside the current address phase.
    longint unsigned m_src, m_dst;
    int              m_ts, m_blen, m_beats;

    function automatic int eff_burst();
        return (cfg_burst_size == 0) ? 1 : int'(cfg_burst_size);
    endfunction

    function automatic longint unsigned step_of();
        return (cfg_hsize >= 2) ? 64'd4 : (64'd1 << cfg_hsize);
    endfunction

    task automatic model_reset();
        m_src   = 0;
        m_dst   = 0;
        m_ts    = 0;
        m_blen  = 1;
        m_beats = 0;
    endtask

    task automatic model_clock();
        longint unsigned n_src, n_dst;
        int n_ts, n_blen, n_beats;
        if (!rst_n) begin
            model_reset();
            return;
        end
        n_src   = m_src;
        n_dst   = m_dst;
        n_ts    = m_ts;
        n_blen  = m_blen;
        n_beats = m_beats;
        if (s_en) n_src = s_sel ? 64'(cfg_src_addr) : (m_src + step_of()) % (64'd1 << 32);
        if (d_en) n_dst = d_sel ? 64'(cfg_dst_addr) : (m_dst + step_of()) % (64'd1 << 32);
        if (ts_en) n_ts = t_sel ? int'(cfg_trans_size) : ((m_ts > m_blen) ? m_ts - m_blen : 0);
        if (burst_en) begin
            n_blen  = b_sel ? (((m_ts % 32) == 0) ? 1 : m_ts % 32) : eff_burst();
            n_beats = 0;
        end else if (count_en) begin
            n_beats = (m_beats + 1) % m_blen;
        end
        m_src   = n_src;
        m_dst   = n_dst;
        m_ts    = n_ts;
        m_blen  = n_blen;
        m_beats = n_beats;
    endtask

    task automatic push_expected();
        exp_t e;
        e.src   = m_src;
        e.dst   = m_dst;
        e.ts    = m_ts;
        e.haddr = h_sel ? m_dst : m_src;
        e.hsize = (cfg_hsize == 3) ? 2 : int'(cfg_hsize);
        e.bsz   = (m_beats == 0);
        e.tsz   = (m_ts == 0);
        e.tslb  = (m_ts < eff_burst());
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) -> mon_ev;

    // Monitor: each sample point pops one expectation and compares all outputs.
    always begin
        exp_t e;
        @(mon_ev);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("src_q", 64'(src_q), e.src);
            chk("dst_q", 64'(dst_q), e.dst);
            chk("ts_q",  64'(ts_q),  64'(e.ts));
            chk("haddr", 64'(haddr), e.haddr);
            chk("hsize", 64'(hsize), 64'(e.hsize));
            chk("bsz",   64'(bsz),   64'(e.bsz));
            chk("tsz",   64'(tsz),   64'(e.tsz));
            chk("tslb",  64'(tslb),  64'(e.tslb));
        end
    end

    // One clock with the currently driven inputs; inputs change after negedge.
    task automatic cycle();
        @(posedge clk);
        model_clock();
        push_expected();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        {s_en, d_en, ts_en, burst_en, count_en} = '0;
        {s_sel, d_sel, t_sel, b_sel, h_sel}     = '0;
    endtask

    task automatic load(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] ts,
                        input logic [4:0] burst, input logic [1:0] hs);
        cfg_src_addr   = src;
        cfg_dst_addr   = dst;
        cfg_trans_size = ts;
        cfg_burst_size = burst;
        cfg_hsize      = hs;
        idle();
        {s_en, d_en, ts_en, burst_en} = '1;
        {s_sel, d_sel, t_sel, b_sel}  = '1;
        cycle();
        idle();
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cfg_src_addr = '0; cfg_dst_addr = '0; cfg_trans_size = '0;
        cfg_burst_size = 5'd4; cfg_hsize = 2'd2;
        idle();
        model_reset();
        #1;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Load and flags, then beat counting with source increment.
        load(32'h1000, 32'h2000, 16'd8, 5'd4, 2'd2);
        repeat (4) begin
            count_en = 1'b1; s_en = 1'b1;
            cycle();
        end
        idle();
        h_sel = 1'b1;
        cycle();

        // Size decrement to zero.
        load(32'h1000, 32'h2000, 16'd8, 5'd4, 2'd2);
        repeat (2) begin
            ts_en = 1'b1;
            cycle();
        end

        // Short last burst.
        load(32'h3000, 32'h4000, 16'd6, 5'd4, 2'd1);
        idle(); ts_en = 1'b1; cycle();
        idle(); burst_en = 1'b1; b_sel = 1'b1; cycle();
        idle(); count_en = 1'b1; cycle(); cycle();
        idle(); ts_en = 1'b1; cycle();

        // Burst of zero behaves as one; address wrap; byte step; saturation.
        load(32'hFFFF_FFFC, 32'h0000_0010, 16'd3, 5'd0, 2'd2);
        idle(); count_en = 1'b1; cycle();
        idle(); s_en = 1'b1; cycle();
        idle(); cfg_hsize = 2'd0; s_en = 1'b1; d_en = 1'b1; cycle();
        idle(); cfg_hsize = 2'd3; d_en = 1'b1; cycle();
        load(32'h5000, 32'h6000, 16'd3, 5'd4, 2'd2);
        idle(); ts_en = 1'b1; cycle();

        // Asynchronous reset in the middle of a burst.
        load(32'h7000, 32'h8000, 16'd5, 5'd4, 2'd2);
        idle(); count_en = 1'b1; cycle(); cycle();
        idle(); h_sel = 1'b1;
        @(posedge clk);
        model_clock();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        push_expected();
        -> mon_ev;
        #1;
        push_expected();
        @(negedge clk);
        #1;
        {s_en, d_en, ts_en, burst_en, count_en} = '1;
        {s_sel, d_sel, t_sel, b_sel} = '1;
        cycle();
        idle();
        rst_n = 1'b1;
        load(32'h9000, 32'hA000, 16'd10, 5'd3, 2'd2);

        // Random strobes and occasional reprogramming.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                cfg_src_addr   = $urandom;
                cfg_dst_addr   = $urandom;
                cfg_trans_size = 16'($urandom_range(0, 70));
                cfg_burst_size = 5'($urandom_range(0, 31));
                cfg_hsize      = 2'($urandom_range(0, 3));
            end
            s_en     = ($urandom_range(0, 2) == 0);
            d_en     = ($urandom_range(0, 2) == 0);
            ts_en    = ($urandom_range(0, 3) == 0);
            burst_en = ($urandom_range(0, 5) == 0);
            count_en = ($urandom_range(0, 1) == 0);
            s_sel    = ($urandom_range(0, 7) == 0);
            d_sel    = ($urandom_range(0, 7) == 0);
            t_sel    = ($urandom_range(0, 5) == 0);
            b_sel    = ($urandom_range(0, 1) == 0);
            h_sel    = 1'($urandom_range(0, 1));
            cycle();
        end
        idle();
        cycle();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
